fifo_to_wmst_packer: RTL and testbench

- Store-side counterpart of the load path: pops 32-bit words from the store scfifo (lpm_showahead OFF) and packs them into 128-bit beats for the Avalon write master (mem_top write port).
- Per tile: latches the write address and length, issues one write-master `go`, streams the beats, waits for `wmst_done`, then pulses `store_data_done`.
- Sits between the store scfifo and the write master control/user interface.

---
 rtl/fifo_to_wmst_packer.sv | 151 +++++++++++++++
 tb/tb_fifo_to_wmst_packer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_to_wmst_packer.sv
// Store-side packer: pops 32-bit words from a non-showahead scfifo, packs them
// into 128-bit beats and hands them to the Avalon write master, one tile per start.
module fifo_to_wmst_packer #(
    parameter int unsigned AW  = 12,
    parameter int unsigned DW  = 32,
    parameter int unsigned XAW = 32,
    parameter int unsigned XDW = 128
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [DW-1:0]  param_waddr,
    input  logic [AW-1:0]  param_iolen,
    input  logic           store_data_start,
    output logic           store_data_done,
    output logic           wmst_fixed_location,
    output logic [XAW-1:0] wmst_write_base,
    output logic [XAW-1:0] wmst_write_length,
    output logic           wmst_go,
    input  logic           wmst_done,
    output logic           wmst_user_write_buffer,
    output logic [XDW-1:0] wmst_user_write_data,
    input  logic           wmst_user_buffer_full,
    input  logic [DW-1:0]  wmst_store_data,
    output logic           store_fifo_pop,
    input  logic           store_fifo_empty
);

    localparam int unsigned WCNT = XDW / DW;
    localparam int unsigned WSH  = $clog2(WCNT);
    localparam int unsigned FW   = $clog2(WCNT + 1);

    typedef enum logic [2:0] {StIdle, StGo, StXfer, StWaitDone, StFin} state_e;

    state_e         state_q;
    logic [XAW-1:0] base_q;
    logic [XAW-1:0] len_q;
    logic [AW-1:0]  iolen_q;
    logic [AW-1:0]  nbeats_q;
    logic           go_q;
    logic           done_q;

    logic [AW-1:0]  popped_q;
    logic [AW-1:0]  beats_q;
    logic [FW-1:0]  fill_q;
    logic           inflight_q;
    logic           beat_valid_q;
    logic [XDW-1:0] beat_q;

    logic [AW-1:0]  nbeats_c;
    logic           start_c;

    // Beats per tile, rounded up; the last beat may be partially filled.
    assign nbeats_c = AW'(({1'b0, param_iolen} + (AW + 1)'(WCNT - 1)) >> WSH);
    assign start_c  = (state_q == StIdle) && store_data_start;

    // Pop only while the pending beat has room for the word plus any word still in flight.
    assign store_fifo_pop = (state_q == StXfer) && !store_fifo_empty &&
                            (popped_q < iolen_q) &&
                            ((fill_q + FW'(inflight_q)) < FW'(WCNT)) && !beat_valid_q;

    assign wmst_user_write_buffer = beat_valid_q && !wmst_user_buffer_full;
    assign wmst_user_write_data   = beat_q;
    assign wmst_fixed_location    = 1'b0;
    assign wmst_write_base        = base_q;
    assign wmst_write_length      = len_q;
    assign wmst_go                = go_q;
    assign store_data_done        = done_q;

    // Tile sequencing FSM with registered go/done pulses and latched tile parameters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            base_q   <= '0;
            len_q    <= '0;
            iolen_q  <= '0;
            nbeats_q <= '0;
            go_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            go_q   <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (store_data_start) begin
                        base_q   <= XAW'(param_waddr);
                        len_q    <= XAW'(nbeats_c) * XAW'(XDW / 8);
                        iolen_q  <= param_iolen;
                        nbeats_q <= nbeats_c;
                        if (param_iolen == '0) begin
                            state_q <= StFin;
                        end else begin
                            state_q <= StGo;
                            go_q    <= 1'b1;
                        end
                    end
                end
                StGo: state_q <= StXfer;
                StXfer: begin
                    if (beats_q == nbeats_q) state_q <= StWaitDone;
                end
                StWaitDone: begin
                    if (wmst_done) state_q <= StFin;
                end
                StFin: begin
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Word capture into lanes, beat formation and beat handshake bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            popped_q     <= '0;
            beats_q      <= '0;
            fill_q       <= '0;
            inflight_q   <= 1'b0;
            beat_valid_q <= 1'b0;
            beat_q       <= '0;
        end else if (start_c) begin
            popped_q     <= '0;
            beats_q      <= '0;
            fill_q       <= '0;
            inflight_q   <= 1'b0;
            beat_valid_q <= 1'b0;
            beat_q       <= '0;
        end else begin
            inflight_q <= store_fifo_pop;
            if (store_fifo_pop) popped_q <= popped_q + AW'(1);
            // FIFO q is valid the cycle after the pop; popped_q already counts that word.
            if (inflight_q) begin
                for (int unsigned l = 0; l < WCNT; l++) begin
                    if (fill_q == FW'(l)) beat_q[l*DW +: DW] <= wmst_store_data;
                end
                fill_q <= fill_q + FW'(1);
                if (((fill_q + FW'(1)) == FW'(WCNT)) || (popped_q == iolen_q)) begin
                    beat_valid_q <= 1'b1;
                end
            end
            if (wmst_user_write_buffer) begin
                beat_valid_q <= 1'b0;
                beat_q       <= '0;
                fill_q       <= '0;
                beats_q      <= beats_q + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_to_wmst_packer.sv
// Self-checking bench for fifo_to_wmst_packer: FIFO and write-master models plus
// a tile-level scoreboard of expected beats, pop counts, go and done pulses.
module tb_fifo_to_wmst_packer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  param_waddr = '0;
    logic [11:0]  param_iolen = '0;
    logic         store_data_start = 1'b0;
    logic         sdone;
    logic         fixed_loc;
    logic [31:0]  wbase;
    logic [31:0]  wlen;
    logic         wgo;
    logic         wmst_done = 1'b0;
    logic         wbuf;
    logic [127:0] wdata;
    logic         full = 1'b0;
    logic [31:0]  store_data = '0;
    logic         pop;
    logic         store_fifo_empty = 1'b1;

    fifo_to_wmst_packer dut (
        .clk                    (clk),
        .rst                    (rst),
        .param_waddr            (param_waddr),
        .param_iolen            (param_iolen),
        .store_data_start       (store_data_start),
        .store_data_done        (sdone),
        .wmst_fixed_location    (fixed_loc),
        .wmst_write_base        (wbase),
        .wmst_write_length      (wlen),
        .wmst_go                (wgo),
        .wmst_done              (wmst_done),
        .wmst_user_write_buffer (wbuf),
        .wmst_user_write_data   (wdata),
        .wmst_user_buffer_full  (full),
        .wmst_store_data        (store_data),
        .store_fifo_pop         (pop),
        .store_fifo_empty       (store_fifo_empty)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Tile model state
    logic [31:0]  fq[$];
    logic [127:0] exp_beats[$];
    logic [127:0] wr_log[$];
    logic [31:0]  tile_addr = '0;
    logic [31:0]  tile_len  = '0;
    int           tile_iolen = 0;
    int           go_cnt = 0, pop_cnt = 0, done_cnt = 0;
    int           cyc = 0, last_wr_cyc = 0, done_cyc = 0;
    logic [31:0]  go_base = '0, go_len = '0;
    bit           stall_test = 0, prev_full = 0, tile_active = 0;
    int           stall_cyc = 0;
    int           force_dly = -1;
    int           dly = 0;

    // Non-showahead FIFO: q appears the cycle after the pop, empty is registered.
    always @(posedge clk) begin
        if (pop === 1'b1) begin
            chk("fifo_underflow", fq.size() > 0, 1);
            if (fq.size() > 0) store_data <= fq.pop_front();
        end
        store_fifo_empty <= (fq.size() == 0);
    end

    // Write master: drops done on go, raises it some cycles after the last beat.
    always @(posedge clk) begin
        #2;
        if (rst) begin
            wmst_done = 1'b0;
        end else if (wgo) begin
            wmst_done = 1'b0;
            dly = (force_dly >= 0) ? force_dly : int'($urandom_range(0, 4));
        end else if (tile_active && go_cnt > 0 && exp_beats.size() == 0 && !wmst_done) begin
            if (dly == 0) wmst_done = 1'b1;
            else dly--;
        end
    end

    // Per-cycle compare against the tile scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (wgo) begin
                go_cnt++;
                go_base = wbase;
                go_len  = wlen;
                chk("go_base", wbase, tile_addr);
                chk("go_length", wlen, tile_len);
            end
            if (pop) begin
                pop_cnt++;
                chk("pop_not_empty", store_fifo_empty, 0);
                chk("pop_within_iolen", pop_cnt <= tile_iolen, 1);
            end
            if (wbuf) begin
                chk("wr_not_full", full, 0);
                chk("wr_beat_expected", exp_beats.size() > 0, 1);
                if (exp_beats.size() > 0) chk("beat_data", wdata, exp_beats.pop_front());
                wr_log.push_back(wdata);
                last_wr_cyc = cyc;
            end
            if (stall_test && full) begin
                stall_cyc++;
                chk("stall_no_pop", pop, 0);
                if (stall_cyc >= 3 && exp_beats.size() > 0) begin
                    chk("stall_no_wr", wbuf, 0);
                    chk("stall_data", wdata, exp_beats[0]);
                end
            end
            if (stall_test && prev_full && !full) chk("wr_on_release", wbuf, 1);
            if (sdone) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_after_beats", exp_beats.size(), 0);
                chk("done_pops", pop_cnt, tile_iolen);
                chk("done_base_stable", wbase, tile_addr);
                chk("done_len_stable", wlen, tile_len);
                chk("fixed_location", fixed_loc, 0);
            end
            prev_full = full;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setup_tile(input logic [31:0] addr, input int len, input int extra,
                              input bit seq, input bit stall, input int fdly,
                              output logic [31:0] words[$]);
        fq.delete();
        exp_beats.delete();
        wr_log.delete();
        words.delete();
        for (int i = 0; i < len + extra; i++) words.push_back(seq ? 32'(i + 1) : $urandom);
        for (int b = 0; b * 4 < len; b++) begin
            logic [127:0] bt;
            bt = '0;
            for (int l = 0; l < 4 && b * 4 + l < len; l++) bt[l*32 +: 32] = words[b*4+l];
            exp_beats.push_back(bt);
        end
        tile_addr  = addr;
        tile_iolen = len;
        tile_len   = 32'(((len + 3) / 4) * 16);
        go_cnt     = 0;
        pop_cnt    = 0;
        done_cnt   = 0;
        stall_test = stall;
        stall_cyc  = 0;
        force_dly  = fdly;
        tile_active = 1;
    endtask

    task automatic run_tile(input logic [31:0] addr, input int len, input int extra,
                            input int gap, input bit stall, input bit rfull,
                            input int fdly, input bit seq);
        logic [31:0] words[$];
        int fed, stall_left, guard;
        bit stall_started;
        setup_tile(addr, len, extra, seq, stall, fdly, words);
        fed = 0;
        if (gap == 0) begin
            foreach (words[i]) fq.push_back(words[i]);
            fed = words.size();
        end
        param_waddr = addr;
        param_iolen = 12'(len);
        store_data_start = 1'b1;
        step();
        store_data_start = 1'b0;
        guard = 0;
        stall_started = 0;
        stall_left = 0;
        while (done_cnt == 0 && guard < 2000) begin
            if (gap > 0 && fed < words.size() && guard % gap == 0) begin
                fq.push_back(words[fed]);
                fed++;
            end
            if (stall) begin
                if (!stall_started && pop_cnt == 4) begin
                    full = 1'b1;
                    stall_started = 1;
                    stall_left = 10;
                end else if (stall_left > 0) begin
                    stall_left--;
                    if (stall_left == 0) full = 1'b0;
                end
            end else if (rfull) begin
                full = ($urandom_range(0, 2) == 0);
            end
            step();
            guard++;
        end
        full = 1'b0;
        chk("tile_timeout", done_cnt > 0, 1);
        repeat (4) step();
        chk("done_once", done_cnt, 1);
        chk("go_once", go_cnt, (len > 0) ? 1 : 0);
        chk("pops_total", pop_cnt, len);
        chk("beats_left", exp_beats.size(), 0);
        tile_active = 0;
        stall_test  = 0;
    endtask

    initial begin
        logic [31:0] words[$];
        int guard;

        repeat (3) step();
        chk("reset_ctrl", {wgo, sdone, wbuf, pop, fixed_loc}, 0);
        chk("reset_base", wbase, 0);
        chk("reset_length", wlen, 0);
        chk("reset_wdata", wdata, 0);
        rst = 1'b0;
        step();

        // Prefilled tile of 8 words
        run_tile(32'h1000, 8, 0, 0, 0, 0, 0, 1);
        chk("t1_beat0", wr_log[0], 128'h00000004_00000003_00000002_00000001);
        chk("t1_beat1", wr_log[1], 128'h00000008_00000007_00000006_00000005);
        chk("t1_go_base", go_base, 32'h1000);
        chk("t1_go_len", go_len, 32'd32);
        chk("t1_done_latency", done_cyc - last_wr_cyc, 4);

        // Same tile with a 10-cycle buffer-full stall on beat 1
        run_tile(32'h1000, 8, 0, 0, 1, 0, 2, 1);
        chk("t2_beat0", wr_log[0], 128'h00000004_00000003_00000002_00000001);
        chk("t2_beat1", wr_log[1], 128'h00000008_00000007_00000006_00000005);

        // Slow FIFO feed, one word every 3 cycles
        run_tile(32'h2000, 4, 0, 3, 0, 0, 1, 1);
        chk("t3_beat0", wr_log[0], 128'h00000004_00000003_00000002_00000001);

        // Partial last beat, with spare words left in the FIFO
        run_tile(32'h3000, 6, 2, 0, 0, 0, 0, 1);
        chk("t4_go_len", go_len, 32'd32);
        chk("t4_beat1", wr_log[1], 128'h00000000_00000000_00000006_00000005);
        chk("t4_fifo_left", fq.size(), 2);

        // Zero-length tile: done two cycles after start, no go, no pops
        setup_tile(32'h6000, 0, 0, 1, 0, 0, words);
        param_waddr = 32'h6000;
        param_iolen = '0;
        store_data_start = 1'b1;
        @(negedge clk) chk("zero_done_c0", sdone, 0);
        step();
        store_data_start = 1'b0;
        @(negedge clk) chk("zero_done_c1", sdone, 0);
        step();
        @(negedge clk) chk("zero_done_c2", sdone, 1);
        step();
        @(negedge clk) chk("zero_done_c3", sdone, 0);
        chk("zero_go", go_cnt, 0);
        chk("zero_pops", pop_cnt, 0);
        tile_active = 0;

        // Abort by reset after the first beat, with an ignored start during the transfer
        step();
        setup_tile(32'h1000, 8, 0, 1, 0, 0, words);
        foreach (words[i]) fq.push_back(words[i]);
        param_waddr = 32'h1000;
        param_iolen = 12'd8;
        store_data_start = 1'b1;
        step();
        store_data_start = 1'b0;
        step();
        param_waddr = 32'h5000;
        param_iolen = 12'd3;
        store_data_start = 1'b1;
        step();
        store_data_start = 1'b0;
        guard = 0;
        while (wr_log.size() == 0 && guard < 200) begin
            step();
            guard++;
        end
        chk("rst_first_beat", wr_log.size(), 1);
        chk("rst_base_kept", wbase, 32'h1000);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_async_ctrl", {wgo, sdone, wbuf, pop, fixed_loc}, 0);
        chk("rst_async_base", wbase, 0);
        chk("rst_async_length", wlen, 0);
        chk("rst_async_wdata", wdata, 0);
        step();
        step();
        rst = 1'b0;
        repeat (8) step();
        chk("rst_no_done", done_cnt, 0);
        chk("rst_single_go", go_cnt, 1);
        tile_active = 0;

        run_tile(32'h4000, 5, 1, 0, 0, 0, 1, 1);
        chk("post_rst_beat1", wr_log[1], 128'h00000000_00000000_00000000_00000005);

        // Randomised tiles: random data, lengths, feed rate and backpressure
        for (int t = 0; t < 10; t++) begin
            run_tile($urandom & 32'hffff_fff0, int'($urandom_range(1, 13)),
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 0, 1, -1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
